// File: rtl/sobolflex_idx_if.sv
// -----------------------------------------------------------------------------
// sobolflex_idx_if -- request/result bundle for the Sobol index sequencer.
//
// Signals (requester side = master, sequencer side = slave):
//   iStart  burst request, honoured only while the sequencer is idle
//   iChan   channel (0/1) of the requested burst
//   iLen    number of points in the burst, 0 means 2^BITWIDTH
//   iEn     advance enable, 0 stalls a running burst
//   iClr    synchronous clear of both channels and of the burst
//   oOneHot registered one-hot direction-vector select
//   oSel    registered channel select
//   oClr    registered clear for the downstream core
//   oBusy   high while a burst is running
//   oDone   one-cycle pulse on burst completion
//   oWrap   (only with SOBOLFLEX_IDX_WRAP_EN) pulse on a point issued from
//           an all-ones counter
// -----------------------------------------------------------------------------
interface sobolflex_idx_if #(
  parameter int BITWIDTH = 8
);
  logic                iStart;
  logic                iChan;
  logic [BITWIDTH-1:0] iLen;
  logic                iEn;
  logic                iClr;
  logic [BITWIDTH-1:0] oOneHot;
  logic                oSel;
  logic                oClr;
  logic                oBusy;
  logic                oDone;
`ifdef SOBOLFLEX_IDX_WRAP_EN
  logic                oWrap;
`endif

  modport master (
    output iStart, iChan, iLen, iEn, iClr,
`ifdef SOBOLFLEX_IDX_WRAP_EN
    input  oWrap,
`endif
    input  oOneHot, oSel, oClr, oBusy, oDone
  );

  modport slave (
    input  iStart, iChan, iLen, iEn, iClr,
`ifdef SOBOLFLEX_IDX_WRAP_EN
    output oWrap,
`endif
    output oOneHot, oSel, oClr, oBusy, oDone
  );
endinterface

// File: rtl/sobolflex_idx.sv
// -----------------------------------------------------------------------------
// sobolflex_idx -- two-channel Gray-code index sequencer for a Sobol core.
//
// Each channel owns a BITWIDTH-bit point counter. A burst of iLen points on
// one channel emits, per advancing cycle, the one-hot position of the lowest
// zero bit of that channel's counter (the direction vector the downstream
// Sobol core must XOR in), then increments the counter. All outputs are
// registered, giving one cycle of latency from the advancing edge.
//
// Ports:
//   iClk   clock, rising edge
//   iRstN  asynchronous active-low reset
//   bus    sobolflex_idx_if.slave (request inputs, registered outputs)
//
// Optional feature: define SOBOLFLEX_IDX_WRAP_EN to add bus.oWrap, a
// one-cycle pulse aligned with a point issued from an all-ones counter.
// -----------------------------------------------------------------------------
module sobolflex_idx #(
  parameter int BITWIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  sobolflex_idx_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [BITWIDTH-1:0] r_cnt0;
  logic [BITWIDTH-1:0] r_cnt1;
  logic [BITWIDTH:0]   r_rem;     // one extra bit so 2^BITWIDTH fits
  logic                r_chan;
  logic [BITWIDTH-1:0] r_onehot;
  logic                r_clr;
  logic                r_busy;
  logic                r_done;
`ifdef SOBOLFLEX_IDX_WRAP_EN
  logic                r_wrap;
`endif

  logic [BITWIDTH-1:0] w_cur;
  logic [BITWIDTH-1:0] w_inc;
  logic [BITWIDTH-1:0] w_onehot;
  logic                w_last;

  assign w_cur = r_chan ? r_cnt1 : r_cnt0;
  assign w_inc = w_cur + BITWIDTH'(1);
  // ~c & (c+1) isolates the lowest zero bit of c; for an all-ones counter
  // c+1 wraps to zero, so the select is zero exactly when no zero bit exists.
  assign w_onehot = ~w_cur & w_inc;
  assign w_last   = (r_rem == (BITWIDTH+1)'(1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state  <= S_IDLE;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_rem    <= '0;
      r_chan   <= 1'b0;
      r_onehot <= '0;
      r_clr    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SOBOLFLEX_IDX_WRAP_EN
      r_wrap   <= 1'b0;
`endif
    end else begin
      // NOTE: pulse-style outputs get a default every cycle; the branches
      // below only raise them, so nothing holds a stale value.
      r_onehot <= '0;
      r_done   <= 1'b0;
      r_clr    <= bus.iClr;
`ifdef SOBOLFLEX_IDX_WRAP_EN
      r_wrap   <= 1'b0;
`endif
      if (bus.iClr) begin
        // Clear wins over start and enable; the channel register is kept so
        // oSel does not glitch for the downstream core.
        r_state <= S_IDLE;
        r_cnt0  <= '0;
        r_cnt1  <= '0;
        r_rem   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.iStart) begin
              r_chan  <= bus.iChan;
              r_rem   <= (bus.iLen == '0) ? {1'b1, {BITWIDTH{1'b0}}}
                                          : {1'b0, bus.iLen};
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
          S_RUN: begin
            if (bus.iEn) begin
              r_onehot <= w_onehot;
              if (r_chan) r_cnt1 <= w_inc;
              else        r_cnt0 <= w_inc;
              r_rem <= r_rem - (BITWIDTH+1)'(1);
`ifdef SOBOLFLEX_IDX_WRAP_EN
              r_wrap <= &w_cur;
`endif
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.oOneHot = r_onehot;
  assign bus.oSel    = r_chan;
  assign bus.oClr    = r_clr;
  assign bus.oBusy   = r_busy;
  assign bus.oDone   = r_done;
`ifdef SOBOLFLEX_IDX_WRAP_EN
  assign bus.oWrap   = r_wrap;
`endif

endmodule

// File: tb/tb_sobolflex_idx.sv
// -----------------------------------------------------------------------------
// tb_sobolflex_idx -- self-checking bench for sobolflex_idx (BITWIDTH = 4).
// A burst-level reference model tracks what every output must be; a compare
// process checks the DUT against it on every falling edge. Directed scenarios
// pin the model with hand-computed sequences, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_sobolflex_idx;
  localparam int W = 4;
  localparam int NPTS = 2 ** W;

  logic clk;
  logic rst_n;

  sobolflex_idx_if #(.BITWIDTH(W)) u_if ();

  sobolflex_idx #(.BITWIDTH(W)) u_dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit busy;
    bit done;
    int rem;
    bit chan;
    int cnt0;
    int cnt1;
    int onehot;
    bit clr;
    bit wrap;
  } m_t;

  m_t m;

  // Position of the first 0 bit, scanning upward from bit 0; none -> 0.
  function automatic int lowest_zero(input int v);
    for (int i = 0; i < W; i++)
      if (((v >> i) & 1) == 0) return (1 << i);
    return 0;
  endfunction

  function automatic m_t model_next(input m_t s, input bit st, input bit ch,
                                    input int len, input bit en, input bit clr);
    m_t n;
    int c;
    n = s;
    n.onehot = 0;
    n.wrap   = 1'b0;
    n.done   = 1'b0;
    n.clr    = clr;
    if (clr) begin
      n.busy = 1'b0;
      n.rem  = 0;
      n.cnt0 = 0;
      n.cnt1 = 0;
    end else if (s.done) begin
      // completion cycle: back to idle, requests ignored
    end else if (!s.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.chan = ch;
        n.rem  = (len == 0) ? NPTS : len;
      end
    end else if (en) begin
      c = s.chan ? s.cnt1 : s.cnt0;
      n.onehot = lowest_zero(c);
      n.wrap   = (c == NPTS - 1);
      c = (c + 1) % NPTS;
      if (s.chan) n.cnt1 = c;
      else        n.cnt0 = c;
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        n.busy = 1'b0;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m, u_if.iStart, u_if.iChan, int'(u_if.iLen),
                         u_if.iEn, u_if.iClr);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cmp_onehot", int'(u_if.oOneHot), m.onehot);
    check("cmp_sel",    int'(u_if.oSel),    int'(m.chan));
    check("cmp_clr",    int'(u_if.oClr),    int'(m.clr));
    check("cmp_busy",   int'(u_if.oBusy),   int'(m.busy));
    check("cmp_done",   int'(u_if.oDone),   int'(m.done));
`ifdef SOBOLFLEX_IDX_WRAP_EN
    check("cmp_wrap",   int'(u_if.oWrap),   int'(m.wrap));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    u_if.iStart = 1'b0;
    u_if.iChan  = 1'b0;
    u_if.iLen   = '0;
    u_if.iEn    = 1'b0;
    u_if.iClr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_onehot", int'(u_if.oOneHot), 0);
    check("rst_busy",   int'(u_if.oBusy),   0);
    check("rst_sel",    int'(u_if.oSel),    0);
    rst_n = 1'b1;
    step();
  endtask

  // Request a burst; returns once the sequencer is in RUN (no point yet).
  task automatic start_burst(input bit ch, input int len);
    u_if.iStart = 1'b1;
    u_if.iChan  = ch;
    u_if.iLen   = W'(len);
    u_if.iEn    = 1'b1;
    step();
    u_if.iStart = 1'b0;
  endtask

  // Advance one point and check the literal select value.
  task automatic expect_point(input string name, input int exp);
    step();
    check(name, int'(u_if.oOneHot), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Four points on channel 0 from a fresh counter.
    start_burst(1'b0, 4);
    check("r30_busy_run", int'(u_if.oBusy), 1);
    expect_point("r30_p0", 4'b0001);
    expect_point("r30_p1", 4'b0010);
    expect_point("r30_p2", 4'b0001);
    expect_point("r30_p3", 4'b0100);
    check("r30_done",  int'(u_if.oDone), 1);
    check("r30_busy0", int'(u_if.oBusy), 0);
    step();
    check("r30_done_once", int'(u_if.oDone), 0);
    check("r30_cnt0", int'(u_dut.r_cnt0), 4);

    // Full-length burst (iLen=0) on channel 1 wraps its counter.
    do_reset();
    start_burst(1'b1, 0);
    for (int i = 0; i < NPTS; i++) begin
      step();
      if (i == 0) check("r31_p0", int'(u_if.oOneHot), 4'b0001);
      if (i == 7) check("r31_p7", int'(u_if.oOneHot), 4'b1000);
      if (i < NPTS - 1) check("r31_no_done", int'(u_if.oDone), 0);
    end
    check("r31_last", int'(u_if.oOneHot), 0);
    check("r31_done", int'(u_if.oDone), 1);
    check("r31_sel",  int'(u_if.oSel), 1);
`ifdef SOBOLFLEX_IDX_WRAP_EN
    check("r31_wrap", int'(u_if.oWrap), 1);
`endif
    step();
    check("r31_cnt1", int'(u_dut.r_cnt1), 0);

    // Interleaved channels keep independent counters.
    do_reset();
    start_burst(1'b0, 2);
    expect_point("r32_a0", 4'b0001);
    expect_point("r32_a1", 4'b0010);
    step();
    start_burst(1'b1, 2);
    expect_point("r32_b0", 4'b0001);
    check("r32_sel1", int'(u_if.oSel), 1);
    expect_point("r32_b1", 4'b0010);
    step();
    check("r32_sel_hold", int'(u_if.oSel), 1);
    start_burst(1'b0, 2);
    expect_point("r32_c0", 4'b0001);
    check("r32_sel0", int'(u_if.oSel), 0);
    expect_point("r32_c1", 4'b0100);
    step();

    // Stall for three cycles mid-burst.
    do_reset();
    start_burst(1'b0, 4);
    expect_point("r33_p0", 4'b0001);
    u_if.iEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r33_stall_zero", int'(u_if.oOneHot), 0);
      check("r33_stall_busy", int'(u_if.oBusy), 1);
    end
    u_if.iEn = 1'b1;
    expect_point("r33_p1", 4'b0010);
    expect_point("r33_p2", 4'b0001);
    expect_point("r33_p3", 4'b0100);
    check("r33_done", int'(u_if.oDone), 1);
    step();

    // Clear together with start, mid-burst.
    do_reset();
    start_burst(1'b0, 4);
    expect_point("r34_p0", 4'b0001);
    u_if.iClr   = 1'b1;
    u_if.iStart = 1'b1;
    step();
    check("r34_oclr",   int'(u_if.oClr),    1);
    check("r34_onehot", int'(u_if.oOneHot), 0);
    check("r34_busy",   int'(u_if.oBusy),   0);
    check("r34_done",   int'(u_if.oDone),   0);
    idle_inputs();
    step();
    check("r34_oclr_low", int'(u_if.oClr),  0);
    check("r34_no_done",  int'(u_if.oDone), 0);
    check("r34_idle",     int'(u_if.oBusy), 0);
    start_burst(1'b0, 2);
    expect_point("r34_restart", 4'b0001);
    step();
    step();

    // Asynchronous reset mid-burst.
    start_burst(1'b1, 4);
    expect_point("r35_p0", 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("r35_onehot", int'(u_if.oOneHot), 0);
    check("r35_sel",    int'(u_if.oSel),    0);
    check("r35_busy",   int'(u_if.oBusy),   0);
    check("r35_done",   int'(u_if.oDone),   0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("r35_no_done", int'(u_if.oDone), 0);
    end
    start_burst(1'b1, 1);
    expect_point("r35_restart", 4'b0001);
    step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      u_if.iStart = ($urandom_range(0, 3) == 0);
      u_if.iChan  = 1'($urandom_range(0, 1));
      u_if.iLen   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 6));
      u_if.iEn    = ($urandom_range(0, 3) != 0);
      u_if.iClr   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("rnd_async_busy", int'(u_if.oBusy), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sobolflex_idx.md
SOBOLFLEX_IDX -- requirements
Module: sobolflex_idx

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: width of the per-channel index counters, oOneHot and iLen.
REQ-002 SHALL have port iClk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iStart  input  1  burst request, sampled only in IDLE.
REQ-005 SHALL have port iChan  input  1  channel (0/1) for the requested burst, captured with iStart.
REQ-006 SHALL have port iLen  input  BITWIDTH  points in the burst, captured with iStart; 0 encodes 2^BITWIDTH.
REQ-007 SHALL have port iEn  input  1  advance enable; 0 stalls a running burst.
REQ-008 SHALL have port iClr  input  1  synchronous clear of both channels and of the burst.
REQ-009 SHALL have port oOneHot  output  BITWIDTH  registered one-hot direction-vector select for the downstream Sobol core.
REQ-010 SHALL have port oSel  output  1  registered channel select for the downstream core.
REQ-011 SHALL have port oClr  output  1  registered clear for the downstream core.
REQ-012 SHALL have port oBusy  output  1  high in RUN.
REQ-013 SHALL have port oDone  output  1  one-cycle pulse on burst completion.

Function
REQ-014 SHALL keep two independent index counters cnt0, cnt1, each BITWIDTH bits.
REQ-015 SHALL implement FSM IDLE -> RUN (iStart in IDLE) -> DONE (last point issued) -> IDLE (unconditionally next cycle).
REQ-016 SHALL, on iStart in IDLE, capture iChan into a channel register and iLen into a remaining-count register (BITWIDTH+1 bits, 0 loaded as 2^BITWIDTH).
REQ-017 SHALL ignore iStart in RUN and DONE.
REQ-018 SHALL, on each RUN cycle with iEn=1, register oOneHot = one-hot of the lowest zero bit of cnt[chan], increment cnt[chan], and decrement the remaining count.
REQ-019 SHALL register oOneHot = 0 when cnt[chan] is all ones (no zero bit); the counter wraps to 0.
REQ-020 SHALL register oOneHot = 0 in IDLE, in DONE, and in RUN with iEn=0; counters and remaining count hold.
REQ-021 SHALL enter DONE on the edge that issues the point with remaining count 1; oDone=1 and oBusy=0 in DONE only.
REQ-022 SHALL drive oSel from the channel register at all times, so it remains stable after a burst ends.
REQ-023 SHALL leave the counter of the non-selected channel unchanged during a burst.
REQ-024 SHALL give one-cycle latency: oOneHot, oSel and oClr for a point appear the cycle after the advancing edge, aligned for the downstream core.
REQ-025 SHALL, on iClr=1 in any state (priority over iStart and iEn), zero cnt0, cnt1 and the remaining count, go to IDLE, register oClr=1 and oOneHot=0, and produce no oDone pulse.

Reset
REQ-026 SHALL, while iRstN=0, asynchronously force IDLE, cnt0=cnt1=0, remaining count=0, channel register=0, oOneHot=0, oSel=0, oClr=0, oBusy=0, oDone=0.
REQ-027 SHALL abort any burst on reset mid-operation without an oDone pulse; after release, operation restarts from index 0 on both channels.

Configuration
REQ-028 SHALL, with macro SOBOLFLEX_IDX_WRAP_EN defined, add port oWrap  output  1, a registered one-cycle pulse on the cycle the point is issued from an all-ones counter; cleared by reset and iClr.
REQ-029 SHALL, without SOBOLFLEX_IDX_WRAP_EN, have no oWrap port and no wrap-flag logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover, with BITWIDTH=4: reset, iStart, iChan=0, iLen=4, iEn=1 -> oOneHot 0001,0010,0001,0100 on consecutive cycles, then oDone for exactly 1 cycle, cnt0=4.
REQ-031 SHALL cover iLen=0 on channel 1 -> 16 points, 16th oOneHot=0000, cnt1 wraps to 0, oWrap=1 on that point when SOBOLFLEX_IDX_WRAP_EN is defined.
REQ-032 SHALL cover a burst of 2 on ch0, then a burst of 2 on ch1, then a burst of 2 on ch0 -> ch1 gives 0001,0010; the second ch0 burst gives 0001,0100; oSel tracks the channel.
REQ-033 SHALL cover iEn low for 3 cycles mid-burst -> oOneHot=0000 during the stall, sequence resumes unbroken, oBusy stays 1.
REQ-034 SHALL cover iClr asserted mid-burst together with iStart -> oClr=1 the next cycle, IDLE, no oDone, next burst starts at 0001.
REQ-035 SHALL cover iRstN pulled low mid-burst, asynchronous to iClk -> all outputs 0 immediately, no oDone after release.
